// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states,
// opcode and funct values, ALUOp codes and ALUControl codes.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011100;

    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b100;
    localparam logic [2:0] ALUCTL_SLT = 3'b110;
    localparam logic [2:0] ALUCTL_MUL = 3'b101;

endpackage

// File: rtl/ALU_Decoder.sv
// Maps the controller's ALUOp (and the funct field for R-type) to the
// 3-bit ALU operation code.
module ALU_Decoder
    import mips_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl
);

    // ALUOp selects a fixed operation except for R-type, which uses funct
    always_comb begin
        ALUControl = ALUCTL_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALUCTL_ADD;
            ALUOP_SUB: ALUControl = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FUNCT_ADD: ALUControl = ALUCTL_ADD;
                    FUNCT_SUB: ALUControl = ALUCTL_SUB;
                    FUNCT_SLT: ALUControl = ALUCTL_SLT;
                    FUNCT_MUL: ALUControl = ALUCTL_MUL;
                    default:   ALUControl = ALUCTL_ADD;
                endcase
            end
            default:   ALUControl = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main controller: Moore sequencing FSM plus ALU decode.
// Memory-dependent strobes in FETCH follow MemReady in the same cycle.
module mips_mc_controller
    import mips_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalOp
);

    state_t state_reg, state_next;
    // Remembers lw vs sw from DECODE so MEMADR does not look at Op again
    logic   is_sw_reg, is_sw_next;

    aluop_t alu_op;
    logic   pc_write;
    logic   branch;
    logic   ir_write;
    logic   mem_write;
    logic   reg_write;
    logic   illegal;

    // State register; reset drops straight back to FETCH without a clock
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= FETCH;
            is_sw_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            is_sw_reg <= is_sw_next;
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        state_next = state_reg;
        is_sw_next = is_sw_reg;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        case (state_reg)
            FETCH: begin
                ALUSrcB = 2'b01;
                if (MemReady) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                is_sw_next = (Op == OP_SW);
                case (Op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXEC;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default: begin
                        illegal    = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = is_sw_reg ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD = 1'b1;
                if (MemReady) state_next = MEMWB;
            end
            MEMWB: begin
                MemtoReg   = 1'b1;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
                if (MemReady) state_next = FETCH;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                RegDst     = 1'b1;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
                state_next = FETCH;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                PCSrc      = 2'b10;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Write strobes are held off for as long as reset is low, including
    // the FETCH strobes that would otherwise follow MemReady
    assign PCEn      = RST & (pc_write | (branch & Zero));
    assign IRWrite   = RST & ir_write;
    assign MemWrite  = RST & mem_write;
    assign RegWrite  = RST & reg_write;
    assign IllegalOp = RST & illegal;

    ALU_Decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .Funct      (Funct),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench: each instruction pushes its expected per-cycle output
// vectors; each test drains the queue one clock at a time and compares.
module tb_mips_mc_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       IllegalOp;

    int errors = 0;
    int checks = 0;

    localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMRD = 3,
                   T_MEMWB = 4, T_MEMWR = 5, T_EXEC = 6, T_ALUWB = 7,
                   T_BRANCH = 8, T_ADDIEX = 9, T_ADDIWB = 10, T_JUMP = 11;

    localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011,
                           BEQ_OP = 6'b000100, ADDI_OP = 6'b001000, J_OP = 6'b000010;

    typedef struct {
        int          st;
        bit          mr;
        bit          z;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] exp;
    } cyc_t;

    cyc_t q[$];

    mips_mc_controller dut (
        .CLK        (CLK),
        .RST        (RST),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .IllegalOp  (IllegalOp)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] observed();
        return {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, PCSrc, ALUControl, IllegalOp};
    endfunction

    function automatic logic [2:0] fdec(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b100;
            6'b101010: return 3'b110;
            6'b011100: return 3'b101;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op == R_OP || op == LW_OP || op == SW_OP || op == BEQ_OP ||
               op == ADDI_OP || op == J_OP;
    endfunction

    // Expected outputs for one cycle in a given state
    function automatic logic [15:0] model(input int st, input bit mr, input bit z,
                                          input logic [5:0] op, input logic [5:0] fn);
        logic pcen, iord, memw, irw, rd, m2r, rw, sa, ill;
        logic [1:0] sb, ps;
        logic [2:0] ctl;
        {pcen, iord, memw, irw, rd, m2r, rw, sa, ill} = '0;
        sb = 2'b00; ps = 2'b00; ctl = 3'b010;
        case (st)
            T_FETCH:  begin sb = 2'b01; irw = mr; pcen = mr; end
            T_DECODE: begin sb = 2'b11; ill = !legal(op); end
            T_MEMADR, T_ADDIEX: begin sa = 1'b1; sb = 2'b10; end
            T_MEMRD:  iord = 1'b1;
            T_MEMWB:  begin m2r = 1'b1; rw = 1'b1; end
            T_MEMWR:  begin iord = 1'b1; memw = 1'b1; end
            T_EXEC:   begin sa = 1'b1; ctl = fdec(fn); end
            T_ALUWB:  begin rd = 1'b1; rw = 1'b1; end
            T_BRANCH: begin sa = 1'b1; ps = 2'b01; ctl = 3'b100; pcen = z; end
            T_ADDIWB: rw = 1'b1;
            T_JUMP:   begin ps = 2'b10; pcen = 1'b1; end
            default:  ;
        endcase
        return {pcen, iord, memw, irw, rd, m2r, rw, sa, sb, ps, ctl, ill};
    endfunction

    task automatic push(input int st, input bit mr, input bit z,
                        input logic [5:0] op, input logic [5:0] fn);
        cyc_t c;
        c.st = st; c.mr = mr; c.z = z; c.op = op; c.fn = fn;
        c.exp = model(st, mr, z, op, fn);
        q.push_back(c);
    endtask

    // Queue one instruction; op_after is driven on Op once DECODE is over
    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                         input int fwait, input int mwait, input logic [5:0] op_after);
        for (int i = 0; i < fwait; i++) push(T_FETCH, 1'b0, z, op, fn);
        push(T_FETCH, 1'b1, z, op, fn);
        push(T_DECODE, 1'b1, z, op, fn);
        case (op)
            LW_OP: begin
                push(T_MEMADR, 1'b1, z, op_after, fn);
                for (int i = 0; i < mwait; i++) push(T_MEMRD, 1'b0, z, op_after, fn);
                push(T_MEMRD, 1'b1, z, op_after, fn);
                push(T_MEMWB, 1'b1, z, op_after, fn);
            end
            SW_OP: begin
                push(T_MEMADR, 1'b1, z, op_after, fn);
                for (int i = 0; i < mwait; i++) push(T_MEMWR, 1'b0, z, op_after, fn);
                push(T_MEMWR, 1'b1, z, op_after, fn);
            end
            R_OP: begin
                push(T_EXEC, 1'b1, z, op_after, fn);
                push(T_ALUWB, 1'b1, z, op_after, fn);
            end
            BEQ_OP:  push(T_BRANCH, 1'b1, z, op_after, fn);
            ADDI_OP: begin
                push(T_ADDIEX, 1'b1, z, op_after, fn);
                push(T_ADDIWB, 1'b1, z, op_after, fn);
            end
            J_OP:    push(T_JUMP, 1'b1, z, op_after, fn);
            default: ;
        endcase
    endtask

    // Apply one queued cycle, sample mid-cycle, leave at posedge+1
    task automatic step(output logic [15:0] obs, output logic [15:0] expv, output int st);
        cyc_t c;
        c = q.pop_front();
        MemReady = c.mr; Zero = c.z; Op = c.op; Funct = c.fn;
        @(negedge CLK);
        obs  = observed();
        expv = c.exp;
        st   = c.st;
        @(posedge CLK);
        #1;
    endtask

    localparam logic [15:0] RESET_VEC = 16'b0000_0000_01_00_010_0;

    task automatic test_reset();
        logic [15:0] o;
        RST = 1'b0; MemReady = 1'b1; Zero = 1'b1; Op = LW_OP; Funct = 6'b0;
        #2;
        o = observed(); checks++;
        if (o !== RESET_VEC) begin errors++; $display("FAIL reset_t0 got=%h want=%h", o, RESET_VEC); end
        @(negedge CLK);
        o = observed(); checks++;
        if (o !== RESET_VEC) begin errors++; $display("FAIL reset_hold got=%h want=%h", o, RESET_VEC); end
        @(posedge CLK); #1;
        o = observed(); checks++;
        if (o !== RESET_VEC) begin errors++; $display("FAIL reset_edge got=%h want=%h", o, RESET_VEC); end
        RST = 1'b1;
        $display("txn reset checks=3");
    endtask

    task automatic test_rtype();
        logic [15:0] o, e; int st, n;
        logic [5:0] fl[5] = '{6'b011100, 6'b100000, 6'b100010, 6'b101010, 6'b111111};
        foreach (fl[k]) begin
            instr(R_OP, fl[k], k[0], 0, 0, R_OP);
            n = 0;
            while (q.size() > 0) begin
                step(o, e, st); n++; checks++;
                if (o !== e) begin errors++; $display("FAIL rtype funct=%b st=%0d got=%h want=%h", fl[k], st, o, e); end
            end
            $display("txn rtype funct=%b cycles=%0d", fl[k], n);
        end
    endtask

    task automatic test_load_store();
        logic [15:0] o, e; int st, n;
        int mw[4] = '{0, 3, 0, 2};
        logic [5:0] ops[4] = '{LW_OP, LW_OP, SW_OP, SW_OP};
        foreach (ops[k]) begin
            instr(ops[k], 6'b0, 1'b1, 0, mw[k], ops[k]);
            n = 0;
            while (q.size() > 0) begin
                step(o, e, st); n++; checks++;
                if (o !== e) begin errors++; $display("FAIL ldst op=%b st=%0d got=%h want=%h", ops[k], st, o, e); end
            end
            $display("txn ldst op=%b memwait=%0d cycles=%0d", ops[k], mw[k], n);
        end
    endtask

    task automatic test_branch_jump();
        logic [15:0] o, e; int st, n;
        logic [5:0] ops[5] = '{BEQ_OP, BEQ_OP, ADDI_OP, J_OP, ADDI_OP};
        bit zs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        foreach (ops[k]) begin
            instr(ops[k], 6'b100010, zs[k], (k == 4) ? 2 : 0, 0, ops[k]);
            n = 0;
            while (q.size() > 0) begin
                step(o, e, st); n++; checks++;
                if (o !== e) begin errors++; $display("FAIL brj op=%b st=%0d got=%h want=%h", ops[k], st, o, e); end
            end
            $display("txn brj op=%b zero=%0d cycles=%0d", ops[k], zs[k], n);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] o, e; int st, n;
        logic [5:0] ops[2] = '{6'b111111, 6'b000011};
        foreach (ops[k]) begin
            instr(ops[k], 6'b0, 1'b1, 0, 0, ops[k]);
            push(T_FETCH, 1'b0, 1'b1, ops[k], 6'b0);
            n = 0;
            while (q.size() > 0) begin
                step(o, e, st); n++; checks++;
                if (o !== e) begin errors++; $display("FAIL illegal op=%b st=%0d got=%h want=%h", ops[k], st, o, e); end
            end
            $display("txn illegal op=%b cycles=%0d", ops[k], n);
        end
    endtask

    task automatic test_op_change();
        logic [15:0] o, e; int st, n;
        logic [5:0] ops[3]   = '{LW_OP, SW_OP, R_OP};
        logic [5:0] after[3] = '{SW_OP, LW_OP, BEQ_OP};
        foreach (ops[k]) begin
            instr(ops[k], 6'b101010, 1'b1, 0, 1, after[k]);
            n = 0;
            while (q.size() > 0) begin
                step(o, e, st); n++; checks++;
                if (o !== e) begin errors++; $display("FAIL opchange op=%b st=%0d got=%h want=%h", ops[k], st, o, e); end
            end
            $display("txn opchange op=%b after=%b cycles=%0d", ops[k], after[k], n);
        end
    endtask

    task automatic test_reset_mid_memrd();
        logic [15:0] o, e; int st, n;
        push(T_FETCH, 1'b1, 1'b0, LW_OP, 6'b0);
        push(T_DECODE, 1'b1, 1'b0, LW_OP, 6'b0);
        push(T_MEMADR, 1'b1, 1'b0, LW_OP, 6'b0);
        push(T_MEMRD, 1'b0, 1'b0, LW_OP, 6'b0);
        push(T_MEMRD, 1'b0, 1'b0, LW_OP, 6'b0);
        while (q.size() > 0) begin
            step(o, e, st); checks++;
            if (o !== e) begin errors++; $display("FAIL rstmid_pre st=%0d got=%h want=%h", st, o, e); end
        end
        MemReady = 1'b0;
        RST = 1'b0;
        #1;
        o = observed(); checks++;
        if (o !== RESET_VEC) begin errors++; $display("FAIL rstmid_async got=%h want=%h", o, RESET_VEC); end
        MemReady = 1'b1;
        @(negedge CLK);
        o = observed(); checks++;
        if (o !== RESET_VEC) begin errors++; $display("FAIL rstmid_hold got=%h want=%h", o, RESET_VEC); end
        @(posedge CLK); #1;
        RST = 1'b1;
        push(T_FETCH, 1'b0, 1'b0, J_OP, 6'b0);
        instr(J_OP, 6'b0, 1'b0, 0, 0, J_OP);
        n = 0;
        while (q.size() > 0) begin
            step(o, e, st); n++; checks++;
            if (o !== e) begin errors++; $display("FAIL rstmid_post st=%0d got=%h want=%h", st, o, e); end
        end
        $display("txn reset_mid_memrd post_cycles=%0d", n);
    endtask

    task automatic test_back_to_back();
        logic [15:0] o, e; int st, n;
        logic [5:0] ops[10] = '{R_OP, LW_OP, SW_OP, BEQ_OP, ADDI_OP, J_OP,
                                6'b111111, R_OP, LW_OP, BEQ_OP};
        logic [5:0] fn, oa;
        bit z;
        int mw;
        foreach (ops[k]) begin
            fn = 6'($urandom);
            if (k[0]) fn = 6'b011100;
            oa = 6'($urandom);
            z  = 1'($urandom);
            mw = int'($urandom_range(0, 2));
            instr(ops[k], fn, z, 0, mw, oa);
            n = 0;
            while (q.size() > 0) begin
                step(o, e, st); n++; checks++;
                if (o !== e) begin errors++; $display("FAIL b2b op=%b st=%0d got=%h want=%h", ops[k], st, o, e); end
            end
            $display("txn b2b op=%b funct=%b zero=%0d memwait=%0d cycles=%0d", ops[k], fn, z, mw, n);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_store();
        test_branch_jump();
        test_illegal();
        test_op_change();
        test_reset_mid_memrd();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
